// File: rtl/vga_image_window_if.sv
// Video/ROM bus of vga_image_window.
//   master (the generator): takes win_x, win_y, bg_color, rom_data;
//                            drives rom_addr, hsync, vsync, de, rgb, frame_start
//   slave  (display / ROM / test side): the opposite directions
// Widths come from the interface parameters and must match the generator's.
interface vga_image_window_if #(
  parameter int CW     = 12,
  parameter int RGB_W  = 3,
  parameter int ROM_AW = 11
);
  logic [CW-1:0]     win_x;
  logic [CW-1:0]     win_y;
  logic [RGB_W-1:0]  bg_color;
  logic [ROM_AW-1:0] rom_addr;
  logic [RGB_W-1:0]  rom_data;
  logic              hsync;
  logic              vsync;
  logic              de;
  logic [RGB_W-1:0]  rgb;
  logic              frame_start;

  modport master (
    input  win_x, win_y, bg_color, rom_data,
    output rom_addr, hsync, vsync, de, rgb, frame_start
  );

  modport slave (
    output win_x, win_y, bg_color, rom_data,
    input  rom_addr, hsync, vsync, de, rgb, frame_start
  );
endinterface

// File: rtl/vga_image_window.sv
// Parametrised VGA timing generator with an image window fetched from an
// external synchronous ROM, drawn at a runtime position, scaled by
// 2^SCALE_LOG2, over a runtime background colour.
// Ports:
//   clk  pixel clock
//   rst  synchronous reset, active-high
//   bus  vga_image_window_if.master: window position / background in,
//        ROM address out / ROM data in, registered hsync/vsync/de/rgb and
//        the frame_start pulse out.
// All outputs for a given counter value appear ROM_LAT+2 cycles later, on
// the same cycle.
module vga_image_window #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit SYNC_POL   = 1'b0,
  parameter int CW         = 12,
  parameter int RGB_W      = 3,
  parameter int IMG_W      = 64,
  parameter int IMG_H      = 32,
  parameter int ROM_AW     = 11,
  parameter int ROM_LAT    = 1,
  parameter int SCALE_LOG2 = 0
) (
  input logic                clk,
  input logic                rst,
  vga_image_window_if.master bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int WIN_W   = IMG_W << SCALE_LOG2;
  localparam int WIN_H   = IMG_H << SCALE_LOG2;
  localparam int NP      = ROM_LAT + 1;  // flag stages 1..NP feed the output stage

  typedef struct packed {
    logic act;
    logic inwin;
    logic hs;
    logic vs;
    logic org;
  } flags_t;

  logic [CW-1:0]     h, v;
  logic [CW-1:0]     wx_q, wy_q;
  logic [RGB_W-1:0]  bg_q;
  flags_t            pipe [1:NP];

  // stage 0 decode
  logic              org;
  logic [CW-1:0]     wx, wy, dx, dy;
  logic [CW:0]       he, ve, wxe, wye;
  logic [ROM_AW-1:0] addr0;
  flags_t            f0;
  flags_t            po;

  always_comb begin
    org = (h == '0) && (v == '0);
    // the origin pixel already belongs to the new frame, so it sees the
    // live inputs that the shadows are about to capture
    wx  = org ? bus.win_x : wx_q;
    wy  = org ? bus.win_y : wy_q;
    // one extra bit so wx+width never wraps back into the screen
    he  = {1'b0, h};
    ve  = {1'b0, v};
    wxe = {1'b0, wx};
    wye = {1'b0, wy};
    f0       = '0;
    f0.org   = org;
    f0.act   = (h < CW'(H_ACTIVE)) && (v < CW'(V_ACTIVE));
    f0.hs    = (h >= CW'(H_ACTIVE + H_FP)) && (h < CW'(H_ACTIVE + H_FP + H_SYNC));
    f0.vs    = (v >= CW'(V_ACTIVE + V_FP)) && (v < CW'(V_ACTIVE + V_FP + V_SYNC));
    f0.inwin = f0.act &&
               (he >= wxe) && (he < wxe + (CW+1)'(WIN_W)) &&
               (ve >= wye) && (ve < wye + (CW+1)'(WIN_H));
    dx    = h - wx;
    dy    = v - wy;
    addr0 = ROM_AW'(((32'(dy) >> SCALE_LOG2) * IMG_W) + (32'(dx) >> SCALE_LOG2));
  end

  assign po = pipe[NP];

  always_ff @(posedge clk) begin
    if (rst) begin
      h               <= '0;
      v               <= '0;
      wx_q            <= '0;
      wy_q            <= '0;
      bg_q            <= '0;
      bus.rom_addr    <= '0;
      for (int i = 1; i <= NP; i++) pipe[i] <= '0;
      bus.hsync       <= ~SYNC_POL;
      bus.vsync       <= ~SYNC_POL;
      bus.de          <= 1'b0;
      bus.rgb         <= '0;
      bus.frame_start <= 1'b0;
    end else begin
      // stage 0 counters
      if (h == CW'(H_TOTAL - 1)) begin
        h <= '0;
        v <= (v == CW'(V_TOTAL - 1)) ? '0 : v + 1'b1;
      end else begin
        h <= h + 1'b1;
      end
      if (org) begin
        wx_q <= bus.win_x;
        wy_q <= bus.win_y;
        bg_q <= bus.bg_color;
      end
      // stage 1: address held outside the window
      if (f0.inwin) bus.rom_addr <= addr0;
      // flags ride alongside the ROM latency
      pipe[1] <= f0;
      for (int i = 2; i <= NP; i++) pipe[i] <= pipe[i-1];
      // output stage; bg_q is stable for every active pixel of a frame
      bus.hsync       <= po.hs ^ ~SYNC_POL;
      bus.vsync       <= po.vs ^ ~SYNC_POL;
      bus.de          <= po.act;
      bus.rgb         <= !po.act ? '0 : (po.inwin ? bus.rom_data : bg_q);
      bus.frame_start <= po.org;
    end
  end
endmodule

// File: tb/tb_vga_image_window.sv
// Bench for vga_image_window with a shrunken raster (56x31) so several
// frames fit in a short run. A reference model derived from the raster
// and window rules predicts every output on every cycle.
module tb_vga_image_window;
  localparam int H_ACTIVE = 40, H_FP = 4, H_SYNC = 6, H_BP = 6;
  localparam int V_ACTIVE = 24, V_FP = 2, V_SYNC = 2, V_BP = 3;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FRAME = H_TOTAL * V_TOTAL;
  localparam int CW = 8, RGB_W = 3, IMG_W = 8, IMG_H = 4, ROM_AW = 5;
  localparam int ROM_LAT = 2, SCALE_LOG2 = 1;
  localparam int L = ROM_LAT + 2;
  localparam int SCL = 1 << SCALE_LOG2;

  typedef struct packed {
    logic             hs;
    logic             vs;
    logic             de;
    logic [RGB_W-1:0] rgb;
    logic             fs;
  } out_t;

  localparam out_t IDLE = '{hs: 1'b1, vs: 1'b1, de: 1'b0, rgb: '0, fs: 1'b0};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vga_image_window_if #(.CW(CW), .RGB_W(RGB_W), .ROM_AW(ROM_AW)) bus ();

  vga_image_window #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .SYNC_POL(1'b0), .CW(CW), .RGB_W(RGB_W), .IMG_W(IMG_W), .IMG_H(IMG_H),
    .ROM_AW(ROM_AW), .ROM_LAT(ROM_LAT), .SCALE_LOG2(SCALE_LOG2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // synchronous ROM with ROM_LAT cycles of read latency
  logic [RGB_W-1:0] mem     [IMG_W*IMG_H];
  logic [RGB_W-1:0] rd_pipe [ROM_LAT];
  always @(posedge clk) begin
    rd_pipe[0] <= mem[bus.rom_addr];
    for (int i = 1; i < ROM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.rom_data = rd_pipe[ROM_LAT-1];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // model state: raster position, frame-latched window, future outputs
  int   mh, mv, sx, sy, sb, ra_m;
  out_t exp_q[$];

  // what the screen should show at (h,v); addr = ROM index, -1 outside window
  function automatic out_t ideal(input int h, input int v, input int wx,
                                 input int wy, input int bg, output int addr);
    out_t o;
    bit   act, inw;
    act  = (h < H_ACTIVE) && (v < V_ACTIVE);
    inw  = act && (h >= wx) && (h < wx + IMG_W*SCL) && (v >= wy) && (v < wy + IMG_H*SCL);
    addr = inw ? ((v - wy) / SCL) * IMG_W + (h - wx) / SCL : -1;
    o.hs  = !((h >= H_ACTIVE + H_FP) && (h < H_ACTIVE + H_FP + H_SYNC));
    o.vs  = !((v >= V_ACTIVE + V_FP) && (v < V_ACTIVE + V_FP + V_SYNC));
    o.de  = act;
    o.fs  = (h == 0) && (v == 0);
    o.rgb = !act ? '0 : (inw ? mem[addr] : RGB_W'(bg));
    return o;
  endfunction

  task automatic tick();
    out_t e;
    int   a;
    @(posedge clk);
    #1;
    if (rst) begin
      exp_q.delete();
      repeat (L-1) exp_q.push_back(IDLE);
      e = IDLE; ra_m = 0; mh = 0; mv = 0;
    end else begin
      if (mh == 0 && mv == 0) begin
        sx = int'(bus.win_x); sy = int'(bus.win_y); sb = int'(bus.bg_color);
      end
      exp_q.push_back(ideal(mh, mv, sx, sy, sb, a));
      if (a >= 0) ra_m = a;
      e = exp_q.pop_front();
      mh++;
      if (mh == H_TOTAL) begin
        mh = 0;
        mv = (mv + 1) % V_TOTAL;
      end
    end
    chk("hsync",       32'(bus.hsync),       32'(e.hs));
    chk("vsync",       32'(bus.vsync),       32'(e.vs));
    chk("de",          32'(bus.de),          32'(e.de));
    chk("rgb",         32'(bus.rgb),         32'(e.rgb));
    chk("frame_start", 32'(bus.frame_start), 32'(e.fs));
    chk("rom_addr",    32'(bus.rom_addr),    32'(ra_m));
  endtask

  // occasional mid-frame input changes; only the frame origin may honour them
  task automatic run(input int n);
    repeat (n) begin
      tick();
      if ($urandom_range(0, 99) == 0) bus.bg_color = RGB_W'($urandom);
      if ($urandom_range(0, 299) == 0) bus.win_x = CW'($urandom_range(0, H_ACTIVE));
    end
  endtask

  int wx_tab[8], wy_tab[8];

  initial begin
    for (int i = 0; i < IMG_W*IMG_H; i++) mem[i] = RGB_W'($urandom);
    // origin, clipped right/bottom, right of active area, far off, then random
    wx_tab = '{0, H_ACTIVE-6, H_ACTIVE, 255, 10, 0, 0, 0};
    wy_tab = '{0, V_ACTIVE-3, 5,        255, 8,  0, 0, 0};
    for (int i = 5; i < 8; i++) begin
      wx_tab[i] = $urandom_range(0, H_ACTIVE + 5);
      wy_tab[i] = $urandom_range(0, V_ACTIVE + 3);
    end
    rst = 1'b1;
    bus.win_x = CW'(3);
    bus.win_y = CW'(2);
    bus.bg_color = RGB_W'(5);
    repeat (3) tick();
    rst = 1'b0;
    for (int f = 0; f < 8; f++) begin
      run(FRAME/2 - int'($urandom_range(0, 200)));
      bus.win_x    = CW'(wx_tab[f]);
      bus.win_y    = CW'(wy_tab[f]);
      bus.bg_color = RGB_W'($urandom);
      if (f == 5) begin
        // reset in the middle of the active area
        while (!(mh == 30 && mv == 10)) tick();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
      end
      run(FRAME/2 + 100);
    end
    run(L + 4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
